banked_reg_file: RTL and testbench
==================================

BANKED_REG_FILE -- requirements
Module: banked_reg_file

Interface
REQ-001 SHALL provide parameters: DW, default 8, data width; PA_W, default 4, PORTA width; BANK_W, default 2, RAM bank-select bits; PS_W, default 8, TMR0 prescaler width.
REQ-002 SHALL use a single clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have the following ports:
- f_wr in 1: file write strobe.
- f_adrs in 5: file address.
- f_in_data in DW: write data.
- f_out_data out DW: combinational read data.
- C_en, DC_en, Z_en in 1 each: flag update enables.
- C_new, DC_new, Z_new in 1 each: new flag values.
- PCLl in DW: PC low byte, returned on PCL read.
- tmr0_inc in 1: external TMR0 count event, one cycle per event.
- ps_en in 1: prescaler assigned to TMR0.
- ps_sel in 3: prescale ratio 2^(ps_sel+1).
- SLEEP, CLRWDT, wdt_tmo in 1 each: power and watchdog events.
- porta_in in PA_W: raw PORTA pins.
- portb_in in DW: raw PORTB pins.
- PORTA out PA_W, PORTB out DW: output latches.
- FSR out 5+BANK_W: file select register.
- PA out 3: STATUS page bits.
- C out 1: carry.
- PCL_wr out 1: PCL write strobe.
- tmr0_ovf out 1: one-cycle TMR0 wrap pulse.

Function
REQ-004 SHALL decode effective address ea = (f_adrs==0) ? FSR[4:0] : f_adrs, with bank b = FSR[4+BANK_W:5].
REQ-005 SHALL map SFRs at ea 0..6 as INDF, TMR0, PCL, STATUS, FSR, PORTA, PORTB.
REQ-006 SHALL map ea 0x07-0x0F to unbanked RAM and ea 0x10-0x1F to banked RAM {b, ea[3:0]}, giving 9+16*2^BANK_W words in total.
REQ-007 SHALL treat indirect access with FSR[4:0]==0 as follows: read returns 0; write has no effect.
REQ-008 SHALL return the addressed content combinationally on f_out_data, with these read values:
- STATUS: {PA, T0_N, PD_N, Z, DC, C}.
- PCL: PCLl.
- FSR: FSR with unimplemented upper bits read as 1.
- PORTA: synchronized pins.
- PORTB: synchronized pins.
REQ-009 SHALL write on the clk rising edge when f_wr=1; a write followed by a read in the next cycle SHALL return the new value.
REQ-010 SHALL assert PCL_wr combinationally when f_wr=1 and ea==2; no PCL storage is held here.
REQ-011 SHALL pass porta_in and portb_in through two-flop synchronizers, giving a 2-cycle input latency; writes SHALL go to the PORTA/PORTB latches only.
REQ-012 SHALL run the prescaler, when ps_en=1, as follows:
- count tmr0_inc events in a PS_W-bit counter;
- increment TMR0 when counter bit ps_sel goes 1 -> 0.
REQ-013 SHALL, when ps_en=0, increment TMR0 on each tmr0_inc.
REQ-014 SHALL on a TMR0 write load the value, clear the prescaler, and inhibit increments for the next 2 cycles; inc events during the inhibit are dropped.
REQ-015 SHALL wrap TMR0 from all-ones to 0 and pulse tmr0_ovf for exactly one cycle.
REQ-016 SHALL update each of C/DC/Z from *_new when its *_en=1; enable-driven updates SHALL take priority over a same-cycle STATUS write for that bit.
REQ-017 SHALL let a STATUS write update PA, Z, DC and C (subject to REQ-016); T0_N and PD_N SHALL be read-only.
REQ-018 SHALL update the power-status bits by this priority order:
1. CLRWDT: T0_N=1, PD_N=1.
2. SLEEP: T0_N=1, PD_N=0.
3. wdt_tmo: T0_N=0.
REQ-019 SHALL resolve a simultaneous TMR0 write and increment in favour of the write.

Reset
REQ-020 SHALL on rst_n=0 asynchronously set:
- TMR0=0, prescaler=0, inhibit=0;
- FSR=0, PA=0, T0_N=1, PD_N=1;
- PORTA=0, PORTB=0, synchronizers=0;
- tmr0_ovf=0.
Z, DC and C SHALL be 0. RAM contents SHALL be undefined and need not be reset.
REQ-021 SHALL hold all state at reset values while rst_n=0; the first write SHALL be accepted on the first clk edge after deassertion.

Verification
REQ-022 Indirect banking: write FSR=0x5A, then write INDF=0x3C, then set FSR=0x1A -> reading INDF returns 0 not 0x3C, while reading f_adrs 0x1A with FSR=0x5A returns 0x3C.
REQ-023 TMR0 prescale: ps_en=1, ps_sel=1, with 8 tmr0_inc pulses -> TMR0 advances by 2.
REQ-024 TMR0 write inhibit: write TMR0=0xFF, then apply tmr0_inc on each of the next 3 cycles with ps_en=0 -> TMR0 reads 0xFF for 2 cycles, then 0x00 with tmr0_ovf=1 for one cycle.
REQ-025 Flag priority: STATUS write 0x00 in the same cycle as C_en=1, C_new=1 -> C=1 and Z=DC=0.
REQ-026 Power status: SLEEP -> STATUS[4:3]=2'b10; then wdt_tmo -> 2'b00; then CLRWDT -> 2'b11.
REQ-027 Mid-op reset: assert rst_n=0 mid-count with TMR0=0x80 -> TMR0=0 and FSR=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/banked_reg_file.sv
// banked_reg_file
//   Register file for a small PIC-style core. The SFRs sit at effective
//   addresses 0..6: INDF, TMR0, PCL, STATUS, FSR, PORTA, PORTB. Addresses
//   0x07-0x0F are shared RAM. Addresses 0x10-0x1F are RAM banked by the upper
//   FSR bits. Address 0 goes through FSR[4:0]. Reads are combinational.
//   Writes take effect on the rising edge of clk.
//
// Ports
//   clk, rst_n                rising-edge clock, async active-low reset
//   f_wr, f_adrs, f_in_data   file write strobe, address, write data
//   f_out_data                combinational read data
//   C/DC/Z_en, C/DC/Z_new     per-flag update enables and new values
//   PCLl                      PC low byte, returned on a PCL read
//   tmr0_inc                  TMR0 count event (one cycle per event)
//   ps_en, ps_sel             prescaler assigned to TMR0, ratio 2^(ps_sel+1)
//   SLEEP, CLRWDT, wdt_tmo    power / watchdog events
//   porta_in, portb_in        raw port pins (synchronized internally)
//   PORTA, PORTB              port output latches
//   FSR, PA, C                file select register, STATUS page bits, carry
//   PCL_wr                    PCL write strobe (PCL itself lives elsewhere)
//   tmr0_ovf                  one-cycle TMR0 wrap pulse
module banked_reg_file #(
  parameter int DW     = 8,
  parameter int PA_W   = 4,
  parameter int BANK_W = 2,
  parameter int PS_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                f_wr,
  input  logic [4:0]          f_adrs,
  input  logic [DW-1:0]       f_in_data,
  output logic [DW-1:0]       f_out_data,
  input  logic                C_en,
  input  logic                DC_en,
  input  logic                Z_en,
  input  logic                C_new,
  input  logic                DC_new,
  input  logic                Z_new,
  input  logic [DW-1:0]       PCLl,
  input  logic                tmr0_inc,
  input  logic                ps_en,
  input  logic [2:0]          ps_sel,
  input  logic                SLEEP,
  input  logic                CLRWDT,
  input  logic                wdt_tmo,
  input  logic [PA_W-1:0]     porta_in,
  input  logic [DW-1:0]       portb_in,
  output logic [PA_W-1:0]     PORTA,
  output logic [DW-1:0]       PORTB,
  output logic [5+BANK_W-1:0] FSR,
  output logic [2:0]          PA,
  output logic                C,
  output logic                PCL_wr,
  output logic                tmr0_ovf
);

  localparam int FSR_W     = 5 + BANK_W;
  localparam int UNB_WORDS = 9;
  localparam int RAM_WORDS = UNB_WORDS + 16 * (1 << BANK_W);
  localparam int RAM_AW    = $clog2(RAM_WORDS);

  logic [DW-1:0]     tmr_q, tmr_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [1:0]        inhib_q, inhib_d;
  logic              ovf_q, ovf_d;
  logic [FSR_W-1:0]  fsr_q, fsr_d;
  logic [2:0]        pa_q, pa_d;
  logic              t0n_q, t0n_d, pdn_q, pdn_d;
  logic              z_q, z_d, dc_q, dc_d, c_q, c_d;
  logic [PA_W-1:0]   porta_q, porta_d;
  logic [DW-1:0]     portb_q, portb_d;
  logic [PA_W-1:0]   paMeta_q, paSync_q;
  logic [DW-1:0]     pbMeta_q, pbSync_q;
  logic [DW-1:0]     ram_q [RAM_WORDS];

  logic [4:0]        ea;
  logic [BANK_W-1:0] bank;
  logic              wrEn;
  logic [RAM_AW-1:0] ramIdx;
  logic [PS_W-1:0]   psInc;
  logic              tmrWr;
  logic              bump;

  // Address 0 is INDF: it borrows the low FSR bits. When those are 0 too the
  // access targets nothing, so wrEn masks writes to effective address 0.
  assign ea     = (f_adrs == 5'd0) ? fsr_q[4:0] : f_adrs;
  assign bank   = fsr_q[FSR_W-1:5];
  assign wrEn   = f_wr && (ea != 5'd0);
  assign PCL_wr = f_wr && (ea == 5'd2);
  assign psInc  = ps_q + PS_W'(1);
  assign tmrWr  = wrEn && (ea == 5'd1);

  // The shared words take RAM slots 0..8. The banked words follow them,
  // indexed by {bank, offset}.
  always_comb begin
    if (ea < 5'd16) ramIdx = RAM_AW'(ea - 5'd7);
    else            ramIdx = RAM_AW'(UNB_WORDS) + RAM_AW'({bank, ea[3:0]});
  end

  // Combinational read mux. Unimplemented FSR bits read as 1. Narrow
  // registers are zero-extended.
  always_comb begin
    f_out_data = '0;
    case (ea)
      5'd0:    f_out_data = '0;
      5'd1:    f_out_data = tmr_q;
      5'd2:    f_out_data = PCLl;
      5'd3:    f_out_data = DW'({pa_q, t0n_q, pdn_q, z_q, dc_q, c_q});
      5'd4:    f_out_data = DW'(fsr_q) | ~DW'({FSR_W{1'b1}});
      5'd5:    f_out_data = DW'(paSync_q);
      5'd6:    f_out_data = pbSync_q;
      default: f_out_data = ram_q[ramIdx];
    endcase
  end

  // Next-state logic.
  // A TMR0 write wins over a same-cycle count. It also clears the prescaler
  // and opens a two-cycle window in which count events are dropped.
  // With the prescaler assigned, TMR0 steps when bit ps_sel of the event
  // counter falls. That happens once every 2^(ps_sel+1) events.
  always_comb begin
    tmr_d   = tmr_q;
    ps_d    = ps_q;
    inhib_d = inhib_q;
    ovf_d   = 1'b0;
    bump    = 1'b0;
    fsr_d   = fsr_q;
    pa_d    = pa_q;
    t0n_d   = t0n_q;
    pdn_d   = pdn_q;
    z_d     = z_q;
    dc_d    = dc_q;
    c_d     = c_q;
    porta_d = porta_q;
    portb_d = portb_q;

    if (tmrWr) begin
      tmr_d   = f_in_data;
      ps_d    = '0;
      inhib_d = 2'd2;
    end else begin
      if (inhib_q != 2'd0) begin
        inhib_d = inhib_q - 2'd1;
      end else if (tmr0_inc) begin
        if (ps_en) begin
          ps_d = psInc;
          bump = ps_q[ps_sel] & ~psInc[ps_sel];
        end else begin
          bump = 1'b1;
        end
      end
      if (bump) begin
        tmr_d = tmr_q + DW'(1);
        ovf_d = &tmr_q;
      end
    end

    if (wrEn && (ea == 5'd3)) begin
      pa_d = f_in_data[7:5];
      z_d  = f_in_data[2];
      dc_d = f_in_data[1];
      c_d  = f_in_data[0];
    end
    if (Z_en)  z_d  = Z_new;
    if (DC_en) dc_d = DC_new;
    if (C_en)  c_d  = C_new;

    if (CLRWDT) begin
      t0n_d = 1'b1;
      pdn_d = 1'b1;
    end else if (SLEEP) begin
      t0n_d = 1'b1;
      pdn_d = 1'b0;
    end else if (wdt_tmo) begin
      t0n_d = 1'b0;
    end

    if (wrEn && (ea == 5'd4)) fsr_d   = FSR_W'(f_in_data);
    if (wrEn && (ea == 5'd5)) porta_d = PA_W'(f_in_data);
    if (wrEn && (ea == 5'd6)) portb_d = f_in_data;
  end

  // State registers and the two-flop pin synchronizers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q    <= '0;
      ps_q     <= '0;
      inhib_q  <= '0;
      ovf_q    <= 1'b0;
      fsr_q    <= '0;
      pa_q     <= '0;
      t0n_q    <= 1'b1;
      pdn_q    <= 1'b1;
      z_q      <= 1'b0;
      dc_q     <= 1'b0;
      c_q      <= 1'b0;
      porta_q  <= '0;
      portb_q  <= '0;
      paMeta_q <= '0;
      paSync_q <= '0;
      pbMeta_q <= '0;
      pbSync_q <= '0;
    end else begin
      tmr_q    <= tmr_d;
      ps_q     <= ps_d;
      inhib_q  <= inhib_d;
      ovf_q    <= ovf_d;
      fsr_q    <= fsr_d;
      pa_q     <= pa_d;
      t0n_q    <= t0n_d;
      pdn_q    <= pdn_d;
      z_q      <= z_d;
      dc_q     <= dc_d;
      c_q      <= c_d;
      porta_q  <= porta_d;
      portb_q  <= portb_d;
      paMeta_q <= porta_in;
      paSync_q <= paMeta_q;
      pbMeta_q <= portb_in;
      pbSync_q <= pbMeta_q;
    end
  end

  // General-purpose RAM. It has no reset, so its contents are undefined
  // until software writes them.
  always_ff @(posedge clk) begin
    if (wrEn && (ea >= 5'd7)) ram_q[ramIdx] <= f_in_data;
  end

  assign PORTA    = porta_q;
  assign PORTB    = portb_q;
  assign FSR      = fsr_q;
  assign PA       = pa_q;
  assign C        = c_q;
  assign tmr0_ovf = ovf_q;

endmodule

// File: tb/tb_banked_reg_file.sv
// tb_banked_reg_file
//   Bench for banked_reg_file with default parameters. It runs in three parts:
//   a table of write-then-read vectors; hand sequences for the flag, power,
//   TMR0 and reset corner cases; and a randomized run checked against a
//   behavioural model of the register file.
module tb_banked_reg_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       f_wr;
  logic [4:0] f_adrs;
  logic [7:0] f_in_data;
  logic [7:0] f_out_data;
  logic       C_en, DC_en, Z_en, C_new, DC_new, Z_new;
  logic [7:0] PCLl;
  logic       tmr0_inc, ps_en;
  logic [2:0] ps_sel;
  logic       SLEEP, CLRWDT, wdt_tmo;
  logic [3:0] porta_in;
  logic [7:0] portb_in;
  logic [3:0] PORTA;
  logic [7:0] PORTB;
  logic [6:0] FSR;
  logic [2:0] PA;
  logic       C, PCL_wr, tmr0_ovf;

  int vecCount  = 0;
  int missCount = 0;

  banked_reg_file dut (
    .clk(clk), .rst_n(rst_n), .f_wr(f_wr), .f_adrs(f_adrs),
    .f_in_data(f_in_data), .f_out_data(f_out_data),
    .C_en(C_en), .DC_en(DC_en), .Z_en(Z_en),
    .C_new(C_new), .DC_new(DC_new), .Z_new(Z_new),
    .PCLl(PCLl), .tmr0_inc(tmr0_inc), .ps_en(ps_en), .ps_sel(ps_sel),
    .SLEEP(SLEEP), .CLRWDT(CLRWDT), .wdt_tmo(wdt_tmo),
    .porta_in(porta_in), .portb_in(portb_in),
    .PORTA(PORTA), .PORTB(PORTB), .FSR(FSR), .PA(PA), .C(C),
    .PCL_wr(PCL_wr), .tmr0_ovf(tmr0_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [4:0] adrs;
    logic [7:0] din;
    logic [4:0] rdAdrs;
    logic [7:0] exp;
  } VecT;

  typedef struct {
    logic       wr;
    logic [4:0] adrs;
    logic [7:0] din;
    logic       cEn, dcEn, zEn, cNew, dcNew, zNew;
    logic       inc, psEn;
    logic [2:0] psSel;
    logic       sleep, clrwdt, wdt;
    logic [3:0] pa;
    logic [7:0] pb;
    logic [7:0] pcl;
  } StimT;

  VecT tbl [20];

  // Behavioural model state
  int         mTmr, mPs, mInhibit, mFsr;
  bit         mOvf, mT0n, mPdn, mZ, mDc, mC;
  logic [2:0] mPa;
  logic [3:0] mPortA;
  logic [7:0] mPortB;
  logic [3:0] mPaHist [2];
  logic [7:0] mPbHist [2];
  logic [7:0] mRam [73];
  bit         mValid [73];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    f_wr = 0; f_adrs = 0; f_in_data = 0;
    C_en = 0; DC_en = 0; Z_en = 0; C_new = 0; DC_new = 0; Z_new = 0;
    tmr0_inc = 0; SLEEP = 0; CLRWDT = 0; wdt_tmo = 0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [4:0] adrs, input logic [7:0] din);
    @(negedge clk);
    f_wr = wr; f_adrs = adrs; f_in_data = din;
  endtask

  task automatic endCycle();
    @(negedge clk);
    clearInputs();
  endtask

  task automatic readCheck(input string name, input logic [4:0] adrs, input logic [7:0] exp);
    f_adrs = adrs;
    #1;
    checkOutput(name, 32'(f_out_data), 32'(exp));
  endtask

  function automatic int ramIndex(input int ea, input int bank);
    if (ea < 16) return ea - 7;
    return 9 + bank * 16 + (ea - 16);
  endfunction

  task automatic modelReset();
    mTmr = 0; mPs = 0; mInhibit = 0; mFsr = 0; mOvf = 0;
    mT0n = 1; mPdn = 1; mZ = 0; mDc = 0; mC = 0; mPa = 0;
    mPortA = 0; mPortB = 0;
    mPaHist[0] = 0; mPaHist[1] = 0; mPbHist[0] = 0; mPbHist[1] = 0;
  endtask

  function automatic bit modelRead(input logic [4:0] fa, input logic [7:0] pcl, output logic [7:0] val);
    int ea;
    int idx;
    ea = (fa == 0) ? (mFsr % 32) : int'(fa);
    val = 8'h00;
    modelRead = 1;
    case (ea)
      0: val = 8'h00;
      1: val = 8'(mTmr);
      2: val = pcl;
      3: val = {mPa, mT0n, mPdn, mZ, mDc, mC};
      4: val = 8'(mFsr) | 8'h80;
      5: val = {4'h0, mPaHist[1]};
      6: val = mPbHist[1];
      default: begin
        idx = ramIndex(ea, mFsr / 32);
        val = mRam[idx];
        modelRead = mValid[idx];
      end
    endcase
  endfunction

  task automatic modelStep(input StimT s);
    int ea;
    int bank;
    bit wr;
    bit bump;
    ea   = (s.adrs == 0) ? (mFsr % 32) : int'(s.adrs);
    bank = mFsr / 32;
    wr   = s.wr && (ea != 0);
    bump = 0;
    mOvf = 0;
    if (wr && ea == 1) begin
      mTmr = int'(s.din); mPs = 0; mInhibit = 2;
    end else begin
      if (mInhibit > 0) mInhibit--;
      else if (s.inc) begin
        if (s.psEn) begin
          mPs  = (mPs + 1) % 256;
          bump = (mPs % (1 << (int'(s.psSel) + 1))) == 0;
        end else bump = 1;
      end
      if (bump) begin
        mOvf = (mTmr == 255);
        mTmr = (mTmr + 1) % 256;
      end
    end
    if (wr && ea == 3) begin
      mPa = s.din[7:5]; mZ = s.din[2]; mDc = s.din[1]; mC = s.din[0];
    end
    if (s.zEn)  mZ  = s.zNew;
    if (s.dcEn) mDc = s.dcNew;
    if (s.cEn)  mC  = s.cNew;
    if (s.clrwdt) begin mT0n = 1; mPdn = 1; end
    else if (s.sleep) begin mT0n = 1; mPdn = 0; end
    else if (s.wdt) mT0n = 0;
    if (wr && ea == 4) mFsr = int'(s.din) % 128;
    if (wr && ea == 5) mPortA = s.din[3:0];
    if (wr && ea == 6) mPortB = s.din;
    if (wr && ea >= 7) begin
      mRam[ramIndex(ea, bank)]   = s.din;
      mValid[ramIndex(ea, bank)] = 1;
    end
    mPaHist[1] = mPaHist[0]; mPaHist[0] = s.pa;
    mPbHist[1] = mPbHist[0]; mPbHist[0] = s.pb;
  endtask

  // Called at a falling edge: drive, compare against the model, advance the
  // model, then wait for the next falling edge.
  task automatic runCycle(input StimT s);
    logic [7:0] expRd;
    int ea;
    f_wr = s.wr; f_adrs = s.adrs; f_in_data = s.din;
    C_en = s.cEn; DC_en = s.dcEn; Z_en = s.zEn;
    C_new = s.cNew; DC_new = s.dcNew; Z_new = s.zNew;
    tmr0_inc = s.inc; ps_en = s.psEn; ps_sel = s.psSel;
    SLEEP = s.sleep; CLRWDT = s.clrwdt; wdt_tmo = s.wdt;
    porta_in = s.pa; portb_in = s.pb; PCLl = s.pcl;
    #1;
    ea = (s.adrs == 0) ? (mFsr % 32) : int'(s.adrs);
    if (modelRead(s.adrs, s.pcl, expRd)) checkOutput("rnd_read", 32'(f_out_data), 32'(expRd));
    checkOutput("rnd_pcl_wr", 32'(PCL_wr), 32'(s.wr && ea == 2));
    checkOutput("rnd_fsr", 32'(FSR), 32'(mFsr));
    checkOutput("rnd_c", 32'(C), 32'(mC));
    checkOutput("rnd_pa", 32'(PA), 32'(mPa));
    checkOutput("rnd_porta", 32'(PORTA), 32'(mPortA));
    checkOutput("rnd_portb", 32'(PORTB), 32'(mPortB));
    checkOutput("rnd_ovf", 32'(tmr0_ovf), 32'(mOvf));
    modelStep(s);
    @(negedge clk);
  endtask

  function automatic StimT zeroStim();
    StimT s;
    s = '{default: '0};
    s.pcl = 8'($urandom);
    return s;
  endfunction

  function automatic StimT randStim();
    StimT s;
    s.wr    = ($urandom_range(0, 9) < 4);
    s.adrs  = 5'($urandom);
    s.din   = 8'($urandom);
    s.cEn   = ($urandom_range(0, 3) == 0);
    s.dcEn  = ($urandom_range(0, 3) == 0);
    s.zEn   = ($urandom_range(0, 3) == 0);
    s.cNew  = 1'($urandom);
    s.dcNew = 1'($urandom);
    s.zNew  = 1'($urandom);
    s.inc   = 1'($urandom);
    s.psEn  = 1'($urandom);
    s.psSel = 3'($urandom_range(0, 2));
    s.sleep = ($urandom_range(0, 19) == 0);
    s.clrwdt = ($urandom_range(0, 19) == 0);
    s.wdt   = ($urandom_range(0, 19) == 0);
    s.pa    = 4'($urandom);
    s.pb    = 8'($urandom);
    s.pcl   = 8'($urandom);
    return s;
  endfunction

  initial begin
    StimT s;

    tbl[0]  = '{1'b1, 5'h04, 8'h1A, 5'h04, 8'h9A};
    tbl[1]  = '{1'b1, 5'h00, 8'h00, 5'h00, 8'h00};
    tbl[2]  = '{1'b1, 5'h04, 8'h5A, 5'h04, 8'hDA};
    tbl[3]  = '{1'b1, 5'h00, 8'h3C, 5'h00, 8'h3C};
    tbl[4]  = '{1'b1, 5'h04, 8'h1A, 5'h00, 8'h00};
    tbl[5]  = '{1'b0, 5'h00, 8'h00, 5'h1A, 8'h00};
    tbl[6]  = '{1'b1, 5'h04, 8'h5A, 5'h1A, 8'h3C};
    tbl[7]  = '{1'b1, 5'h07, 8'hA5, 5'h07, 8'hA5};
    tbl[8]  = '{1'b1, 5'h0F, 8'h66, 5'h0F, 8'h66};
    tbl[9]  = '{1'b1, 5'h04, 8'h20, 5'h0F, 8'h66};
    tbl[10] = '{1'b1, 5'h00, 8'h77, 5'h00, 8'h00};
    tbl[11] = '{1'b1, 5'h04, 8'hFF, 5'h04, 8'hFF};
    tbl[12] = '{1'b1, 5'h04, 8'h80, 5'h04, 8'h80};
    tbl[13] = '{1'b1, 5'h03, 8'hFF, 5'h03, 8'hFF};
    tbl[14] = '{1'b1, 5'h03, 8'h00, 5'h03, 8'h18};
    tbl[15] = '{1'b1, 5'h03, 8'hA5, 5'h03, 8'hBD};
    tbl[16] = '{1'b0, 5'h00, 8'h00, 5'h02, 8'h4D};
    tbl[17] = '{1'b1, 5'h05, 8'h0B, 5'h05, 8'h06};
    tbl[18] = '{1'b1, 5'h06, 8'h3C, 5'h06, 8'h81};
    tbl[19] = '{1'b1, 5'h01, 8'h42, 5'h01, 8'h42};

    clearInputs();
    ps_en = 0; ps_sel = 0; porta_in = 4'h6; portb_in = 8'h81; PCLl = 8'h4D;
    rst_n = 0;
    repeat (2) @(negedge clk);

    // State must stay in reset even with a write presented across an edge.
    f_wr = 1; f_adrs = 5'h04; f_in_data = 8'h55;
    @(negedge clk);
    #1;
    checkOutput("rst_fsr", 32'(FSR), 32'h0);
    checkOutput("rst_pa", 32'(PA), 32'h0);
    checkOutput("rst_c", 32'(C), 32'h0);
    checkOutput("rst_ports", 32'({PORTA, PORTB}), 32'h0);
    checkOutput("rst_ovf", 32'(tmr0_ovf), 32'h0);
    readCheck("rst_status", 5'h03, 8'h18);
    readCheck("rst_tmr0", 5'h01, 8'h00);

    // The first edge after release must accept a write.
    @(negedge clk);
    rst_n = 1; f_wr = 1; f_adrs = 5'h04; f_in_data = 8'h11;
    endCycle();
    #1;
    checkOutput("first_write", 32'(FSR), 32'h11);

    $display("[TB] table vectors");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].wr, tbl[i].adrs, tbl[i].din);
      endCycle();
      readCheck($sformatf("tbl%0d", i), tbl[i].rdAdrs, tbl[i].exp);
    end
    checkOutput("porta_latch", 32'(PORTA), 32'hB);
    checkOutput("portb_latch", 32'(PORTB), 32'h3C);
    checkOutput("pa_out", 32'(PA), 32'h5);

    $display("[TB] flag priority");
    applyStimulus(1, 5'h03, 8'hFF); endCycle();
    applyStimulus(1, 5'h03, 8'h00); C_en = 1; C_new = 1; endCycle();
    readCheck("flag_c_prio", 5'h03, 8'h19);
    checkOutput("flag_c_out", 32'(C), 32'h1);
    applyStimulus(1, 5'h03, 8'hFF); Z_en = 1; Z_new = 0; endCycle();
    readCheck("flag_z_prio", 5'h03, 8'hFB);
    applyStimulus(0, 5'h00, 8'h00); DC_en = 1; DC_new = 0; endCycle();
    readCheck("flag_dc_only", 5'h03, 8'hF9);

    $display("[TB] power status");
    applyStimulus(0, 5'h00, 8'h00); SLEEP = 1; endCycle();
    f_adrs = 5'h03; #1; checkOutput("pwr_sleep", 32'(f_out_data[4:3]), 32'h2);
    applyStimulus(0, 5'h00, 8'h00); wdt_tmo = 1; endCycle();
    f_adrs = 5'h03; #1; checkOutput("pwr_wdt", 32'(f_out_data[4:3]), 32'h0);
    applyStimulus(1, 5'h03, 8'hFF); endCycle();
    readCheck("pwr_readonly", 5'h03, 8'hE7);
    applyStimulus(0, 5'h00, 8'h00); CLRWDT = 1; endCycle();
    f_adrs = 5'h03; #1; checkOutput("pwr_clrwdt", 32'(f_out_data[4:3]), 32'h3);
    applyStimulus(0, 5'h00, 8'h00); SLEEP = 1; wdt_tmo = 1; endCycle();
    f_adrs = 5'h03; #1; checkOutput("pwr_sleep_wdt", 32'(f_out_data[4:3]), 32'h2);
    applyStimulus(0, 5'h00, 8'h00); CLRWDT = 1; SLEEP = 1; wdt_tmo = 1; endCycle();
    f_adrs = 5'h03; #1; checkOutput("pwr_all", 32'(f_out_data[4:3]), 32'h3);
    applyStimulus(0, 5'h00, 8'h00); wdt_tmo = 1; endCycle();
    f_adrs = 5'h03; #1; checkOutput("pwr_wdt_only", 32'(f_out_data[4:3]), 32'h1);

    $display("[TB] PCL strobe");
    applyStimulus(1, 5'h02, 8'h00);
    #1; checkOutput("pcl_wr_direct", 32'(PCL_wr), 32'h1);
    f_wr = 0; #1; checkOutput("pcl_wr_idle", 32'(PCL_wr), 32'h0);
    f_wr = 1; f_adrs = 5'h00; #1; checkOutput("pcl_wr_null", 32'(PCL_wr), 32'h0);
    endCycle();
    applyStimulus(1, 5'h04, 8'h02); endCycle();
    applyStimulus(1, 5'h00, 8'h00);
    #1; checkOutput("pcl_wr_indirect", 32'(PCL_wr), 32'h1);
    endCycle();

    $display("[TB] TMR0 write versus increment");
    applyStimulus(1, 5'h01, 8'h10); tmr0_inc = 1; endCycle();
    readCheck("tmr_wr_wins", 5'h01, 8'h10);
    @(negedge clk);
    @(negedge clk); tmr0_inc = 1;
    repeat (3) @(negedge clk);
    tmr0_inc = 0;
    readCheck("tmr_count3", 5'h01, 8'h13);

    $display("[TB] TMR0 write inhibit");
    applyStimulus(1, 5'h01, 8'hFF);
    @(negedge clk); f_wr = 0; tmr0_inc = 1;
    @(negedge clk); readCheck("inhib_c1", 5'h01, 8'hFF);
    checkOutput("inhib_c1_ovf", 32'(tmr0_ovf), 32'h0);
    @(negedge clk); readCheck("inhib_c2", 5'h01, 8'hFF);
    @(negedge clk); tmr0_inc = 0; readCheck("inhib_wrap", 5'h01, 8'h00);
    checkOutput("inhib_ovf", 32'(tmr0_ovf), 32'h1);
    @(negedge clk); #1;
    checkOutput("ovf_one_cycle", 32'(tmr0_ovf), 32'h0);
    readCheck("wrap_hold", 5'h01, 8'h00);

    $display("[TB] TMR0 prescale");
    applyStimulus(1, 5'h01, 8'h00); ps_en = 1; ps_sel = 3'd1; endCycle();
    @(negedge clk);
    @(negedge clk); tmr0_inc = 1;
    repeat (4) @(negedge clk);
    readCheck("ps_half", 5'h01, 8'h01);
    repeat (4) @(negedge clk);
    tmr0_inc = 0; ps_sel = 3'd0;
    readCheck("ps_eight", 5'h01, 8'h02);
    @(negedge clk); tmr0_inc = 1;
    repeat (2) @(negedge clk);
    tmr0_inc = 0; ps_en = 0;
    readCheck("ps_ratio2", 5'h01, 8'h03);

    $display("[TB] mid-count reset");
    applyStimulus(1, 5'h04, 8'h25); endCycle();
    applyStimulus(1, 5'h01, 8'h80); endCycle();
    @(negedge clk);
    @(negedge clk);
    readCheck("pre_rst_tmr", 5'h01, 8'h80);
    tmr0_inc = 1;
    #1 rst_n = 0;
    #1;
    checkOutput("async_rst_tmr", 32'(f_out_data), 32'h0);
    checkOutput("async_rst_fsr", 32'(FSR), 32'h0);
    checkOutput("async_rst_c", 32'(C), 32'h0);
    readCheck("async_rst_status", 5'h03, 8'h18);
    clearInputs();

    $display("[TB] randomized run");
    repeat (2) @(negedge clk);
    rst_n = 1;
    modelReset();
    for (int b = 0; b < 4; b++) begin
      s = zeroStim(); s.wr = 1; s.adrs = 5'h04; s.din = 8'(b * 32);
      runCycle(s);
      for (int a = 7; a < 32; a++) begin
        s = zeroStim(); s.wr = 1; s.adrs = 5'(a); s.din = 8'($urandom);
        runCycle(s);
      end
    end
    for (int n = 0; n < 3000; n++) begin
      s = randStim();
      runCycle(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
